mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master to one-slave arbiter for the core's AXI-lite-style memory port.
- M0 is the instruction-fetch requester and is read-only. M1 is the data load/store requester and can read and write.
- The block sits between the core-side memory interfaces and the single external memory slave.
- One transaction is in flight at a time. The grant is locked from request acceptance until the response handshake completes.

Parameters:
- ADDR_W, 32, address width of ARdata/AWdata.
- DATA_W, 32, width of the read and write data buses.

Ports:
- clock  in  1  clock
- resetn  in  1  synchronous active-low reset
- m0_ARvalid  in  1  M0 read address valid
- m0_ARdata  in  ADDR_W  M0 read address
- m0_arprot  in  3  M0 read protection
- m0_ARready  out  1  M0 read address accepted
- m0_Rvalid  out  1  M0 read data valid
- m0_RReady  in  1  M0 ready for read data
- m1_ARvalid, m1_ARdata, m1_arprot, m1_ARready, m1_Rvalid, m1_RReady  (same as M0)  M1 read channel
- m1_AWvalid  in  1  M1 write address valid
- m1_AWdata  in  ADDR_W  M1 write address
- m1_awprot  in  3  M1 write protection
- m1_AWready  out  1  M1 write address accepted
- m1_Wvalid  in  1  M1 write data valid
- m1_Wdata  in  DATA_W  M1 write data
- m1_Wstrb  in  4  M1 byte strobes
- m1_Wready  out  1  M1 write data accepted
- m1_Bvalid  out  1  M1 write response valid
- m1_Bready  in  1  M1 ready for write response
- Rdata  out  DATA_W  slave read data, broadcast to both masters
- s_ARvalid, s_ARdata, s_arprot  out  slave read address channel
- s_ARready  in  1  slave accepted read address
- s_Rvalid  in  1  slave read data valid
- s_RReady  out  1  ready for slave read data
- s_Rdata  in  DATA_W  slave read data
- s_AWvalid, s_AWdata, s_awprot, s_Wvalid, s_Wdata, s_Wstrb  out  slave write channels
- s_AWready, s_Wready  in  1  slave accepted write address / data
- s_Bvalid  in  1  slave write response valid
- s_Bready  out  1  ready for slave write response
- gnt  out  2  current owner: 00 none, 01 M0 read, 10 M1 read, 11 M1 write

Behaviour:
- FSM states: IDLE, RD0, RD1, WR. State and the aw_done, w_done and ar_done flags are registered. All forwarded signals are combinational from state plus the inputs.
- Reset (synchronous, resetn=0) from any state, including mid-transaction:
  - State goes to IDLE and all flags clear on that edge.
  - All ready/valid outputs to masters and slave are 0 and gnt=00 while in IDLE.
- IDLE:
  - Nothing is forwarded; every ready and valid output is 0.
  - Arbitration among m0_ARvalid, m1_ARvalid and m1_AWvalid|m1_Wvalid selects the next state for the following cycle. Arbitration latency is 1 cycle.
  - M1 requests rank above M0. Within M1, a read ranks above a write.
  - With no request, remain in IDLE.
- RDx:
  - s_ARvalid = mx_ARvalid & !ar_done; address and prot come from Mx.
  - mx_ARready = s_ARready & !ar_done.
  - An AR handshake sets ar_done.
  - s_RReady = mx_RReady; mx_Rvalid = s_Rvalid.
  - Handshake on R (s_Rvalid & mx_RReady) goes to IDLE.
  - The AR and R handshakes may occur in the same cycle.
- WR:
  - AW is forwarded until an AW handshake sets aw_done; W is forwarded until a W handshake sets w_done. Either may complete first, or both in the same cycle.
  - s_Bready = m1_Bready; m1_Bvalid = s_Bvalid.
  - A B handshake goes to IDLE, whether or not aw_done and w_done are set.
- Rdata = s_Rdata unconditionally.
- Non-granted masters always see ready=0 and valid=0.
- A master dropping valid before its handshake is a protocol error. The arbiter stays in its state; there is no timeout.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-read-owner register (reset 0 = M1) gives read priority to the master that did not win the previous read. Writes still lose to any read.
- Undefined: fixed priority as listed above; M0 can be starved by continuous M1 traffic.

Test Plan:
- Reset, then m0_ARvalid=1 with address 0x100 and a slave with 1-cycle ARready and Rvalid one cycle later carrying 0xDEADBEEF → gnt=01 one cycle after request; m0_Rvalid=1 with Rdata=0xDEADBEEF; back to IDLE with gnt=00.
- m0_ARvalid and m1_ARvalid asserted in the same cycle → without the macro, M1 is served first, then M0. With ARB_ROUND_ROBIN_EN, the first grant is M0 (last owner M1), then M1.
- M1 write to 0x200, data 0x12345678, Wstrb=1111, with the slave taking Wready 2 cycles before AWready → each channel is forwarded until its own handshake; B handshake returns to IDLE; m0_ARready stays 0 throughout.
- m1_ARvalid and m1_AWvalid both asserted → read is granted (gnt=10) first, then write (gnt=11).
- resetn=0 in RD1 after the AR handshake but before Rvalid → next cycle gnt=00 and s_RReady=0; a fresh M0 read then completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master / one-slave arbiter for the core memory port.
// M0 = instruction fetch (read only), M1 = load/store (read and write).
// One transaction in flight; the grant is held from request acceptance until
// the response handshake. gnt mirrors the FSM state and doubles as its
// debug view: 00 IDLE, 01 M0 read, 10 M1 read, 11 M1 write.
//
// Handshake rule on every channel: a transfer happens in the cycle where
// both valid and ready are high. Valid must then stay high until that
// cycle; the arbiter never times out a stalled master.
//
// Optional build macro: ARB_ROUND_ROBIN_EN -- alternates read priority
// between M0 and M1 when both request in the same cycle. Undefined gives
// fixed priority: M1 read > M1 write > M0 read.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              resetn,
    // M0 read channel
    input  logic              m0_ARvalid,
    input  logic [ADDR_W-1:0] m0_ARdata,
    input  logic [2:0]        m0_arprot,
    output logic              m0_ARready,
    output logic              m0_Rvalid,
    input  logic              m0_RReady,
    // M1 read channel
    input  logic              m1_ARvalid,
    input  logic [ADDR_W-1:0] m1_ARdata,
    input  logic [2:0]        m1_arprot,
    output logic              m1_ARready,
    output logic              m1_Rvalid,
    input  logic              m1_RReady,
    // M1 write channels
    input  logic              m1_AWvalid,
    input  logic [ADDR_W-1:0] m1_AWdata,
    input  logic [2:0]        m1_awprot,
    output logic              m1_AWready,
    input  logic              m1_Wvalid,
    input  logic [DATA_W-1:0] m1_Wdata,
    input  logic [3:0]        m1_Wstrb,
    output logic              m1_Wready,
    output logic              m1_Bvalid,
    input  logic              m1_Bready,
    // Read data broadcast to both masters
    output logic [DATA_W-1:0] Rdata,
    // Slave read channels
    output logic              s_ARvalid,
    output logic [ADDR_W-1:0] s_ARdata,
    output logic [2:0]        s_arprot,
    input  logic              s_ARready,
    input  logic              s_Rvalid,
    output logic              s_RReady,
    input  logic [DATA_W-1:0] s_Rdata,
    // Slave write channels
    output logic              s_AWvalid,
    output logic [ADDR_W-1:0] s_AWdata,
    output logic [2:0]        s_awprot,
    input  logic              s_AWready,
    output logic              s_Wvalid,
    output logic [DATA_W-1:0] s_Wdata,
    output logic [3:0]        s_Wstrb,
    input  logic              s_Wready,
    input  logic              s_Bvalid,
    output logic              s_Bready,
    // Current owner
    output logic [1:0]        gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD0  = 2'b01,
        RD1  = 2'b10,
        WR   = 2'b11
    } state_t;

    state_t state_q;
    state_t arb_d;
    logic   ar_done_q;
    logic   aw_done_q;
    logic   w_done_q;

    logic   ar_hs;
    logic   r_hs;
    logic   aw_hs;
    logic   w_hs;
    logic   b_hs;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = M0 won the previous read, 0 = M1 did (reset value).
    logic   last_rd_q;
`endif

    // Arbitration: choose the owner for the next cycle from the raw requests.
    always_comb begin
        arb_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        if (m0_ARvalid && m1_ARvalid) begin
            arb_d = last_rd_q ? RD1 : RD0;
        end else if (m1_ARvalid) begin
            arb_d = RD1;
        end else if (m0_ARvalid) begin
            arb_d = RD0;
        end else if (m1_AWvalid || m1_Wvalid) begin
            arb_d = WR;
        end
`else
        if (m1_ARvalid) begin
            arb_d = RD1;
        end else if (m1_AWvalid || m1_Wvalid) begin
            arb_d = WR;
        end else if (m0_ARvalid) begin
            arb_d = RD0;
        end
`endif
    end

    // Channel forwarding: only the granted master is connected to the slave.
    always_comb begin
        m0_ARready = 1'b0;
        m0_Rvalid  = 1'b0;
        m1_ARready = 1'b0;
        m1_Rvalid  = 1'b0;
        m1_AWready = 1'b0;
        m1_Wready  = 1'b0;
        m1_Bvalid  = 1'b0;
        s_ARvalid  = 1'b0;
        s_ARdata   = '0;
        s_arprot   = 3'b000;
        s_RReady   = 1'b0;
        s_AWvalid  = 1'b0;
        s_AWdata   = '0;
        s_awprot   = 3'b000;
        s_Wvalid   = 1'b0;
        s_Wdata    = '0;
        s_Wstrb    = 4'b0000;
        s_Bready   = 1'b0;
        case (state_q)
            RD0: begin
                s_ARvalid  = m0_ARvalid & ~ar_done_q;
                s_ARdata   = m0_ARdata;
                s_arprot   = m0_arprot;
                m0_ARready = s_ARready & ~ar_done_q;
                s_RReady   = m0_RReady;
                m0_Rvalid  = s_Rvalid;
            end
            RD1: begin
                s_ARvalid  = m1_ARvalid & ~ar_done_q;
                s_ARdata   = m1_ARdata;
                s_arprot   = m1_arprot;
                m1_ARready = s_ARready & ~ar_done_q;
                s_RReady   = m1_RReady;
                m1_Rvalid  = s_Rvalid;
            end
            WR: begin
                s_AWvalid  = m1_AWvalid & ~aw_done_q;
                s_AWdata   = m1_AWdata;
                s_awprot   = m1_awprot;
                m1_AWready = s_AWready & ~aw_done_q;
                s_Wvalid   = m1_Wvalid & ~w_done_q;
                s_Wdata    = m1_Wdata;
                s_Wstrb    = m1_Wstrb;
                m1_Wready  = s_Wready & ~w_done_q;
                s_Bready   = m1_Bready;
                m1_Bvalid  = s_Bvalid;
            end
            default: ;
        endcase
    end

    // Handshake detection on the slave side (outputs are zero when not granted).
    always_comb begin
        ar_hs = s_ARvalid & s_ARready;
        r_hs  = s_Rvalid  & s_RReady;
        aw_hs = s_AWvalid & s_AWready;
        w_hs  = s_Wvalid  & s_Wready;
        b_hs  = s_Bvalid  & s_Bready;
    end

    assign Rdata = s_Rdata;
    assign gnt   = state_q;

    // FSM: grant lock, per-channel done flags, read-owner history.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= IDLE;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_rd_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_q   <= arb_d;
                    ar_done_q <= 1'b0;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    if (arb_d == RD0) begin
                        last_rd_q <= 1'b1;
                    end else if (arb_d == RD1) begin
                        last_rd_q <= 1'b0;
                    end
`endif
                end
                RD0, RD1: begin
                    if (ar_hs) begin
                        ar_done_q <= 1'b1;
                    end
                    if (r_hs) begin
                        state_q   <= IDLE;
                        ar_done_q <= 1'b0;
                    end
                end
                WR: begin
                    if (aw_hs) begin
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done_q <= 1'b1;
                    end
                    // B ends the write even if AW/W never completed.
                    if (b_hs) begin
                        state_q   <= IDLE;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a table of per-cycle vectors (inputs
// plus hand-computed outputs) followed by a hand-written reset-mid-read case.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    localparam logic [31:0] A_M0 = 32'h0000_0100;
    localparam logic [31:0] A_M1 = 32'h0000_0300;
    localparam logic [31:0] A_WR = 32'h0000_0200;
    localparam logic [31:0] WDAT = 32'h1234_5678;
    localparam logic [31:0] RDAT = 32'hDEAD_BEEF;

    // Input bits: {m0_AR, m1_AR, m1_AW, m1_W, s_ARready, s_Rvalid, s_AWready, s_Wready, s_Bvalid}
    localparam logic [8:0] I_M0_ARV = 9'h100;
    localparam logic [8:0] I_M1_ARV = 9'h080;
    localparam logic [8:0] I_M1_AWV = 9'h040;
    localparam logic [8:0] I_M1_WV  = 9'h020;
    localparam logic [8:0] I_S_ARR  = 9'h010;
    localparam logic [8:0] I_S_RV   = 9'h008;
    localparam logic [8:0] I_S_AWR  = 9'h004;
    localparam logic [8:0] I_S_WR   = 9'h002;
    localparam logic [8:0] I_S_BV   = 9'h001;

    // Output flag bits (gnt is carried separately)
    localparam logic [11:0] E_M0_ARR = 12'h800;
    localparam logic [11:0] E_M0_RV  = 12'h400;
    localparam logic [11:0] E_M1_ARR = 12'h200;
    localparam logic [11:0] E_M1_RV  = 12'h100;
    localparam logic [11:0] E_M1_AWR = 12'h080;
    localparam logic [11:0] E_M1_WR  = 12'h040;
    localparam logic [11:0] E_M1_BV  = 12'h020;
    localparam logic [11:0] E_S_ARV  = 12'h010;
    localparam logic [11:0] E_S_RR   = 12'h008;
    localparam logic [11:0] E_S_AWV  = 12'h004;
    localparam logic [11:0] E_S_WV   = 12'h002;
    localparam logic [11:0] E_S_BR   = 12'h001;

    // First / second winner when both masters request a read together.
    localparam logic [8:0]  FST_ARV = RR_MODE ? I_M0_ARV : I_M1_ARV;
    localparam logic [8:0]  SND_ARV = RR_MODE ? I_M1_ARV : I_M0_ARV;
    localparam logic [1:0]  FST_GNT = RR_MODE ? 2'b01 : 2'b10;
    localparam logic [1:0]  SND_GNT = RR_MODE ? 2'b10 : 2'b01;
    localparam logic [11:0] FST_ARR = RR_MODE ? E_M0_ARR : E_M1_ARR;
    localparam logic [11:0] SND_ARR = RR_MODE ? E_M1_ARR : E_M0_ARR;
    localparam logic [11:0] FST_RV  = RR_MODE ? E_M0_RV : E_M1_RV;
    localparam logic [11:0] SND_RV  = RR_MODE ? E_M1_RV : E_M0_RV;
    localparam logic [31:0] FST_A   = RR_MODE ? A_M0 : A_M1;
    localparam logic [31:0] SND_A   = RR_MODE ? A_M1 : A_M0;

    typedef struct {
        logic [8:0]  in_bits;
        logic [1:0]  exp_gnt;
        logic [11:0] exp_flags;
        logic [31:0] exp_addr;
    } vec_t;

    logic              clock;
    logic              resetn;
    logic              m0_ARvalid, m0_ARready, m0_Rvalid, m0_RReady;
    logic [ADDR_W-1:0] m0_ARdata;
    logic [2:0]        m0_arprot;
    logic              m1_ARvalid, m1_ARready, m1_Rvalid, m1_RReady;
    logic [ADDR_W-1:0] m1_ARdata;
    logic [2:0]        m1_arprot;
    logic              m1_AWvalid, m1_AWready;
    logic [ADDR_W-1:0] m1_AWdata;
    logic [2:0]        m1_awprot;
    logic              m1_Wvalid, m1_Wready;
    logic [DATA_W-1:0] m1_Wdata;
    logic [3:0]        m1_Wstrb;
    logic              m1_Bvalid, m1_Bready;
    logic [DATA_W-1:0] Rdata;
    logic              s_ARvalid, s_ARready;
    logic [ADDR_W-1:0] s_ARdata;
    logic [2:0]        s_arprot;
    logic              s_Rvalid, s_RReady;
    logic [DATA_W-1:0] s_Rdata;
    logic              s_AWvalid, s_AWready;
    logic [ADDR_W-1:0] s_AWdata;
    logic [2:0]        s_awprot;
    logic              s_Wvalid, s_Wready;
    logic [DATA_W-1:0] s_Wdata;
    logic [3:0]        s_Wstrb;
    logic              s_Bvalid, s_Bready;
    logic [1:0]        gnt;

    int tests_run;
    int tests_failed;
    vec_t vecs[$];

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .resetn(resetn),
        .m0_ARvalid(m0_ARvalid), .m0_ARdata(m0_ARdata), .m0_arprot(m0_arprot),
        .m0_ARready(m0_ARready), .m0_Rvalid(m0_Rvalid), .m0_RReady(m0_RReady),
        .m1_ARvalid(m1_ARvalid), .m1_ARdata(m1_ARdata), .m1_arprot(m1_arprot),
        .m1_ARready(m1_ARready), .m1_Rvalid(m1_Rvalid), .m1_RReady(m1_RReady),
        .m1_AWvalid(m1_AWvalid), .m1_AWdata(m1_AWdata), .m1_awprot(m1_awprot),
        .m1_AWready(m1_AWready), .m1_Wvalid(m1_Wvalid), .m1_Wdata(m1_Wdata),
        .m1_Wstrb(m1_Wstrb), .m1_Wready(m1_Wready), .m1_Bvalid(m1_Bvalid),
        .m1_Bready(m1_Bready), .Rdata(Rdata),
        .s_ARvalid(s_ARvalid), .s_ARdata(s_ARdata), .s_arprot(s_arprot),
        .s_ARready(s_ARready), .s_Rvalid(s_Rvalid), .s_RReady(s_RReady),
        .s_Rdata(s_Rdata),
        .s_AWvalid(s_AWvalid), .s_AWdata(s_AWdata), .s_awprot(s_awprot),
        .s_AWready(s_AWready), .s_Wvalid(s_Wvalid), .s_Wdata(s_Wdata),
        .s_Wstrb(s_Wstrb), .s_Wready(s_Wready), .s_Bvalid(s_Bvalid),
        .s_Bready(s_Bready), .gnt(gnt)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [8:0] in_bits, input logic [1:0] g,
                       input logic [11:0] flags, input logic [31:0] addr);
        vec_t v;
        v.in_bits   = in_bits;
        v.exp_gnt   = g;
        v.exp_flags = flags;
        v.exp_addr  = addr;
        vecs.push_back(v);
    endtask

    task automatic drive_bits(input logic [8:0] b);
        {m0_ARvalid, m1_ARvalid, m1_AWvalid, m1_Wvalid,
         s_ARready, s_Rvalid, s_AWready, s_Wready, s_Bvalid} = b;
    endtask

    function automatic logic [11:0] act_flags();
        return {m0_ARready, m0_Rvalid, m1_ARready, m1_Rvalid, m1_AWready, m1_Wready,
                m1_Bvalid, s_ARvalid, s_RReady, s_AWvalid, s_Wvalid, s_Bready};
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // A: single M0 read, 1-cycle ARready, Rvalid one cycle later
        add(9'h000,                                  2'b00, 12'h000, 32'h0);
        add(I_M0_ARV,                                2'b00, 12'h000, 32'h0);
        add(I_M0_ARV | I_S_ARR,                      2'b01, E_M0_ARR | E_S_ARV | E_S_RR, A_M0);
        add(I_S_RV,                                  2'b01, E_M0_RV | E_S_RR, A_M0);
        add(9'h000,                                  2'b00, 12'h000, 32'h0);
        // B: simultaneous reads; winner holds ARvalid after its AR handshake
        add(I_M0_ARV | I_M1_ARV,                     2'b00, 12'h000, 32'h0);
        add(I_M0_ARV | I_M1_ARV | I_S_ARR,           FST_GNT, FST_ARR | E_S_ARV | E_S_RR, FST_A);
        add(I_M0_ARV | I_M1_ARV | I_S_ARR | I_S_RV,  FST_GNT, FST_RV | E_S_RR, FST_A);
        add(SND_ARV,                                 2'b00, 12'h000, 32'h0);
        add(SND_ARV | I_S_ARR | I_S_RV,              SND_GNT, SND_ARR | SND_RV | E_S_ARV | E_S_RR, SND_A);
        add(9'h000,                                  2'b00, 12'h000, 32'h0);
        // C: write, Wready two cycles before AWready
        add(I_M1_AWV | I_M1_WV,                      2'b00, 12'h000, 32'h0);
        add(I_M1_AWV | I_M1_WV | I_S_WR,             2'b11, E_M1_WR | E_S_AWV | E_S_WV | E_S_BR, A_WR);
        add(I_M1_AWV | I_M1_WV,                      2'b11, E_S_AWV | E_S_BR, A_WR);
        add(I_M1_AWV | I_M1_WV | I_S_AWR,            2'b11, E_M1_AWR | E_S_AWV | E_S_BR, A_WR);
        add(I_S_BV,                                  2'b11, E_M1_BV | E_S_BR, A_WR);
        add(9'h000,                                  2'b00, 12'h000, 32'h0);
        // D: M1 read and write together; read first, then write with AW+W same cycle
        add(I_M1_ARV | I_M1_AWV | I_M1_WV,           2'b00, 12'h000, 32'h0);
        add(I_M1_ARV | I_M1_AWV | I_M1_WV | I_S_ARR, 2'b10, E_M1_ARR | E_S_ARV | E_S_RR, A_M1);
        add(I_M1_AWV | I_M1_WV | I_S_RV,             2'b10, E_M1_RV | E_S_RR, A_M1);
        add(I_M1_AWV | I_M1_WV,                      2'b00, 12'h000, 32'h0);
        add(I_M1_AWV | I_M1_WV | I_S_AWR | I_S_WR,   2'b11, E_M1_AWR | E_M1_WR | E_S_AWV | E_S_WV | E_S_BR, A_WR);
        add(I_S_BV,                                  2'b11, E_M1_BV | E_S_BR, A_WR);
        add(9'h000,                                  2'b00, 12'h000, 32'h0);

        // Static master/slave payloads
        resetn    = 1'b0;
        drive_bits(9'h000);
        m0_ARdata = A_M0;  m0_arprot = 3'b100;
        m1_ARdata = A_M1;  m1_arprot = 3'b001;
        m1_AWdata = A_WR;  m1_awprot = 3'b010;
        m1_Wdata  = WDAT;  m1_Wstrb  = 4'b1111;
        m0_RReady = 1'b1;  m1_RReady = 1'b1;  m1_Bready = 1'b1;
        s_Rdata   = RDAT;

        repeat (2) @(posedge clock);

        // Driver: one vector per cycle, checked mid-cycle
        foreach (vecs[i]) begin
            @(negedge clock);
            resetn = 1'b1;
            drive_bits(vecs[i].in_bits);
            #1;
            chk($sformatf("vec%0d gnt", i), {30'd0, gnt}, {30'd0, vecs[i].exp_gnt});
            chk($sformatf("vec%0d flags", i), {20'd0, act_flags()}, {20'd0, vecs[i].exp_flags});
            if (vecs[i].exp_gnt == 2'b11) begin
                chk($sformatf("vec%0d s_AWdata", i), s_AWdata, vecs[i].exp_addr);
                chk($sformatf("vec%0d s_Wdata", i), s_Wdata, WDAT);
                chk($sformatf("vec%0d s_Wstrb", i), {28'd0, s_Wstrb}, 32'hF);
            end else if (vecs[i].exp_gnt != 2'b00) begin
                chk($sformatf("vec%0d s_ARdata", i), s_ARdata, vecs[i].exp_addr);
            end
            if (vecs[i].in_bits[3]) begin
                chk($sformatf("vec%0d Rdata", i), Rdata, RDAT);
            end
        end

        // E: reset in RD1 after AR handshake, before Rvalid
        @(negedge clock);
        drive_bits(I_M1_ARV);
        #1 chk("E idle gnt", {30'd0, gnt}, 32'd0);
        @(negedge clock);
        drive_bits(I_M1_ARV | I_S_ARR);
        #1 chk("E rd1 gnt", {30'd0, gnt}, 32'd2);
        chk("E rd1 s_ARvalid", {31'd0, s_ARvalid}, 32'd1);
        @(negedge clock);
        drive_bits(9'h000);
        resetn = 1'b0;
        #1 chk("E ar_done s_ARvalid", {31'd0, s_ARvalid}, 32'd0);
        chk("E wait s_RReady", {31'd0, s_RReady}, 32'd1);
        @(negedge clock);
        resetn = 1'b1;
        drive_bits(I_M0_ARV);
        #1 chk("E post-reset gnt", {30'd0, gnt}, 32'd0);
        chk("E post-reset s_RReady", {31'd0, s_RReady}, 32'd0);
        @(negedge clock);
        drive_bits(I_M0_ARV | I_S_ARR);
        #1 chk("E m0 gnt", {30'd0, gnt}, 32'd1);
        chk("E m0 s_ARvalid", {31'd0, s_ARvalid}, 32'd1);
        chk("E m0 s_arprot", {29'd0, s_arprot}, 32'd4);
        @(negedge clock);
        drive_bits(I_S_RV);
        s_Rdata = 32'hCAFE_F00D;
        #1 chk("E m0 Rvalid", {31'd0, m0_Rvalid}, 32'd1);
        chk("E m1 Rvalid", {31'd0, m1_Rvalid}, 32'd0);
        chk("E Rdata", Rdata, 32'hCAFE_F00D);
        @(negedge clock);
        drive_bits(9'h000);
        #1 chk("E final gnt", {30'd0, gnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
